// File: rtl/mod38_pkg.sv
// Shared constants and types for the modulo-38 counter.
package mod38_pkg;

    localparam int unsigned MOD38_MODULUS = 38;
    localparam int unsigned MOD38_WIDTH   = 6;
    localparam int unsigned MOD38_MAX     = MOD38_MODULUS - 1;

    typedef logic [MOD38_WIDTH-1:0] count_t;

endpackage

// File: rtl/mod38_next.sv
// Combinational next-count, load-range check and terminal-count logic.
// MOD38_UPDOWN_EN adds the up_dn direction input.
module mod38_next
    import mod38_pkg::*;
#(
    parameter int unsigned MODULUS = MOD38_MODULUS,
    parameter int unsigned WIDTH   = MOD38_WIDTH
) (
    input  logic [WIDTH-1:0] dout,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
`ifdef MOD38_UPDOWN_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] count_next,
    output logic             range_err,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

    logic up;

    always_comb begin
        count_next = dout;
        range_err  = 1'b0;
        tc         = 1'b0;
`ifdef MOD38_UPDOWN_EN
        up         = up_dn;
`else
        up         = 1'b1;
`endif

        if (load) begin
            if (data > MAX_V) begin
                count_next = '0;
                range_err  = 1'b1;
            end else begin
                count_next = data;
            end
        end else if (en) begin
            // Any out-of-range value falls back to 0 on the next enabled edge.
            if (up) begin
                count_next = (dout >= MAX_V) ? '0 : dout + WIDTH'(1);
            end else if (dout > MAX_V) begin
                count_next = '0;
            end else if (dout == '0) begin
                count_next = MAX_V;
            end else begin
                count_next = dout - WIDTH'(1);
            end
        end

        tc = en && (up ? (dout == MAX_V) : (dout == '0));
    end

endmodule

// File: rtl/mod38_counter.sv
// Loadable modulo-38 counter: count and load_err registers with async active-low reset.
// MOD38_UPDOWN_EN adds the up_dn input for up/down counting.
module mod38_counter
    import mod38_pkg::*;
#(
    parameter int unsigned MODULUS = MOD38_MODULUS,
    parameter int unsigned WIDTH   = MOD38_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
`ifdef MOD38_UPDOWN_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             tc,
    output logic             load_err
);

    logic [WIDTH-1:0] count_next;
    logic             range_err;

    mod38_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .dout       (dout),
        .load       (load),
        .data       (data),
        .en         (en),
`ifdef MOD38_UPDOWN_EN
        .up_dn      (up_dn),
`endif
        .count_next (count_next),
        .range_err  (range_err),
        .tc         (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout     <= '0;
            load_err <= 1'b0;
        end else begin
            dout     <= count_next;
            load_err <= range_err;
        end
    end

endmodule

// File: tb/tb_mod38_counter.sv
// Directed self-checking bench for mod38_counter (MOD38_UPDOWN_EN enables the up/down test).
module tb_mod38_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] data;
    logic       en;
`ifdef MOD38_UPDOWN_EN
    logic       up_dn;
`endif
    logic [5:0] dout;
    logic       tc;
    logic       load_err;

    int errors;
    int checks;

    mod38_counter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .en       (en),
`ifdef MOD38_UPDOWN_EN
        .up_dn    (up_dn),
`endif
        .dout     (dout),
        .tc       (tc),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a falling edge; outputs are sampled at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (dout !== 6'd0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: dout=%0d load_err=%0b expected dout=0 load_err=0", dout, load_err);
        end
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b1;
        data = 6'd17;
        tick();
        load = 1'b0;
        checks++;
        if (dout !== 6'd17) begin
            errors++;
            $display("FAIL reset_preload: dout=%0d expected=17", dout);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dout !== 6'd0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: dout=%0d load_err=%0b expected dout=0 load_err=0", dout, load_err);
        end
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        checks++;
        if (dout !== 6'd0) begin
            errors++;
            $display("FAIL reset_release_hold: dout=%0d expected=0", dout);
        end
    endtask

    task automatic test_load();
        load = 1'b1;
        data = 6'd5;
        en   = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (dout !== 6'd5 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_value: dout=%0d load_err=%0b expected dout=5 load_err=0", dout, load_err);
        end
        tick();
        checks++;
        if (dout !== 6'd5) begin
            errors++;
            $display("FAIL load_hold: dout=%0d expected=5", dout);
        end
        en = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            tick();
            checks++;
            if (dout !== 6'(i)) begin
                errors++;
                $display("FAIL load_count: dout=%0d expected=%0d", dout, i);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [5:0] exp_dout [4];
        logic       exp_tc   [4];
        exp_dout = '{6'd36, 6'd37, 6'd0, 6'd1};
        exp_tc   = '{1'b0, 1'b1, 1'b0, 1'b0};
        load = 1'b1;
        data = 6'd36;
        en   = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout !== exp_dout[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: dout=%0d tc=%0b expected dout=%0d tc=%0b",
                         i, dout, tc, exp_dout[i], exp_tc[i]);
            end
            if (i < 3) tick();
        end
        // tc must stay low at the terminal value while counting is disabled.
        load = 1'b1;
        data = 6'd37;
        en   = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (dout !== 6'd37 || tc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_tc_disabled: dout=%0d tc=%0b expected dout=37 tc=0", dout, tc);
        end
    endtask

    task automatic test_out_of_range();
        logic [5:0] bad_vals [3];
        bad_vals = '{6'd40, 6'd63, 6'd38};
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load = 1'b1;
            data = 6'd12;
            tick();
            data = bad_vals[i];
            tick();
            load = 1'b0;
            checks++;
            if (dout !== 6'd0 || load_err !== 1'b1) begin
                errors++;
                $display("FAIL oor_load[%0d]: dout=%0d load_err=%0b expected dout=0 load_err=1",
                         bad_vals[i], dout, load_err);
            end
            tick();
            checks++;
            if (dout !== 6'd0 || load_err !== 1'b0) begin
                errors++;
                $display("FAIL oor_clear[%0d]: dout=%0d load_err=%0b expected dout=0 load_err=0",
                         bad_vals[i], dout, load_err);
            end
        end
        load = 1'b1;
        data = 6'd37;
        tick();
        load = 1'b0;
        checks++;
        if (dout !== 6'd37 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_max_legal: dout=%0d load_err=%0b expected dout=37 load_err=0", dout, load_err);
        end
    endtask

    task automatic test_priority();
        load = 1'b1;
        data = 6'd20;
        en   = 1'b0;
        tick();
        data = 6'd10;
        en   = 1'b1;
        tick();
        load = 1'b0;
        en   = 1'b0;
        checks++;
        if (dout !== 6'd10) begin
            errors++;
            $display("FAIL prio_load_over_en: dout=%0d expected=10", dout);
        end
        load = 1'b1;
        data = 6'd25;
        rst  = 1'b0;
        #1;
        checks++;
        if (dout !== 6'd0) begin
            errors++;
            $display("FAIL prio_rst_async: dout=%0d expected=0", dout);
        end
        tick();
        checks++;
        if (dout !== 6'd0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL prio_rst_over_load: dout=%0d load_err=%0b expected dout=0 load_err=0", dout, load_err);
        end
        rst  = 1'b1;
        load = 1'b0;
        tick();
    endtask

    task automatic test_full_cycle();
        int tc_count;
        tc_count = 0;
        load = 1'b1;
        data = 6'd0;
        en   = 1'b0;
        tick();
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 38; i++) begin
            if (tc === 1'b1) tc_count++;
            tick();
        end
        en = 1'b0;
        checks++;
        if (dout !== 6'd0) begin
            errors++;
            $display("FAIL full_cycle_return: dout=%0d expected=0", dout);
        end
        checks++;
        if (tc_count != 1) begin
            errors++;
            $display("FAIL full_cycle_tc_pulses: count=%0d expected=1", tc_count);
        end
    endtask

`ifdef MOD38_UPDOWN_EN
    task automatic test_updown();
        logic [5:0] exp_dout [4];
        logic       exp_tc   [4];
        exp_dout = '{6'd1, 6'd0, 6'd37, 6'd36};
        exp_tc   = '{1'b0, 1'b1, 1'b0, 1'b0};
        up_dn = 1'b0;
        load  = 1'b1;
        data  = 6'd1;
        en    = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dout !== exp_dout[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL down_seq[%0d]: dout=%0d tc=%0b expected dout=%0d tc=%0b",
                         i, dout, tc, exp_dout[i], exp_tc[i]);
            end
            if (i < 3) tick();
        end
        load = 1'b1;
        data = 6'd37;
        tick();
        load = 1'b0;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL down_tc_at_max: tc=%0b expected=0", tc);
        end
        up_dn = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL up_tc_at_max: tc=%0b expected=1", tc);
        end
        en = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        load   = 1'b0;
        data   = 6'd0;
        en     = 1'b0;
`ifdef MOD38_UPDOWN_EN
        up_dn  = 1'b1;
`endif
        #1;
        test_reset();
        test_load();
        test_wrap();
        test_out_of_range();
        test_priority();
        test_full_cycle();
`ifdef MOD38_UPDOWN_EN
        test_updown();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod38_counter.md
Name: mod38_counter

Overview:
- Synchronous, loadable modulo-38 up-counter with a 6-bit output. The counter sequences 0..37 and then wraps to 0.
- It is a general-purpose timing and sequencing primitive. Typical uses are frame/slot counting and divide-by-38 tick generation in control paths.
- Supports parallel load, count enable and a terminal-count flag.

Parameters:
- MODULUS, 38, number of states; the count range is 0..MODULUS-1.
- WIDTH, 6, width of data/dout; must satisfy 2**WIDTH >= MODULUS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- load  in  1  synchronous parallel-load strobe.
- data  in  WIDTH  load value.
- en  in  1  count enable.
- dout  out  WIDTH  current count.
- tc  out  1  terminal count: high while dout == MODULUS-1 and en == 1 (combinational).
- load_err  out  1  registered one-cycle pulse: the last load used an out-of-range value.

Behaviour:
- Reset
  - rst = 0 forces dout = 0 and load_err = 0 immediately, with no clock needed.
  - Release is synchronous in effect: the first update occurs on the first rising clk edge with rst = 1.
- Per-edge priority (rst = 1): load > en > hold.
- Load
  - When load = 1 and data < MODULUS: dout <= data on the same edge, with 1-cycle latency. load_err <= 0.
  - When load = 1 and data >= MODULUS (38..63): dout <= 0 and load_err <= 1 for exactly one cycle.
- Count
  - When load = 0 and en = 1: dout <= dout + 1 if dout < MODULUS-1, else dout <= 0 (wrap).
  - When load = 0 and en = 0: dout holds.
  - load_err <= 0 on every non-load edge.
- Simultaneous events
  - load = 1 with en = 1: load wins and no increment occurs that cycle.
  - Reset asserted mid-operation: it overrides everything at once.
- Illegal state: dout can never reach a value >= MODULUS. As a defensive rule, if it ever does, the next enabled edge returns it to 0.
- tc
  - Purely combinational from dout and en.
  - Intended for cascading: the next stage's en = tc.
- All arithmetic is unsigned, WIDTH bits. Compare against MODULUS-1 rather than relying on overflow.

Optional Feature:
- Macro: MOD38_UPDOWN_EN.
- Defined
  - Adds input port up_dn (1 bit): 1 = count up, 0 = count down.
  - Down-count: dout <= dout - 1, with wrap from 0 to MODULUS-1.
  - tc means dout == MODULUS-1 when counting up, and dout == 0 when counting down (en = 1 in both cases).
  - Load and reset behaviour is unchanged.
- Not defined: the up_dn port is absent and the block is up-count only.

Decomposition:
- Package mod38_pkg holds:
  - localparams MOD38_MODULUS = 38 and MOD38_WIDTH = 6.
  - MOD38_MAX = MOD38_MODULUS-1.
  - typedef count_t (logic [MOD38_WIDTH-1:0]).
- One natural sub-module: mod38_next. It is combinational next-value logic with inputs dout, load, data, en and (optional) up_dn, and outputs next count, range error and tc.
- The top level holds the registers, the async reset and the load_err flop.

Test Plan:
- Reset: rst = 0 mid-cycle while dout = 17 -> dout = 0 and load_err = 0 immediately, before the next edge. Release, en = 0 -> dout stays 0.
- Load: load = 1 with data = 5 for one negedge-to-negedge window, en = 0 -> dout = 5 after the next rising edge, then holds at 5. With en = 1 -> 6, 7, ...
- Wrap: load 36, en = 1 -> dout sequence 36, 37 (tc = 1), 0 (tc = 0), 1.
- Out-of-range load: data = 40, load = 1 -> dout = 0, load_err = 1 for one cycle, then 0. data = 63 behaves the same.
- Priority: load = 1 with data = 10 and en = 1 while dout = 20 -> dout = 10, not 21. rst = 0 concurrent with load -> dout = 0.
- With MOD38_UPDOWN_EN: load 1, up_dn = 0, en = 1 -> 1, 0 (tc = 1), 37, 36. Full 38-cycle up-count from 0 returns to 0 with exactly one tc pulse.
